// File: rtl/uart_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_sys_pkg
// Description : Shared definitions for the UART command sequencer: command
//               opcodes, ALU operand register addresses and the controller
//               state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_sys_pkg;

    // Command opcodes (first byte of every command)
    localparam int OP_RF_WR   = 'hAA;   // RF write : addr, data
    localparam int OP_RF_RD   = 'hBB;   // RF read  : addr
    localparam int OP_ALU_OP  = 'hCC;   // ALU      : A, B, fun
    localparam int OP_ALU_NOP = 'hDD;   // ALU      : fun (operands already in RF)

    // RF locations that hold the ALU operands
    localparam int OPND_A_ADDR = 0;
    localparam int OPND_B_ADDR = 1;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_SEND  = 4'd9,
        ST_TX_GAP   = 4'd10,
        ST_TX_WAIT  = 4'd11
    } sys_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/sys_ctrl_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl_tx_seq
// Description : Schedules one or two response bytes onto the UART TX
//               interface, LSB byte first. A byte is only launched while
//               the transmitter is idle; after each launch one cycle is
//               skipped so the transmitter has time to raise its busy flag.
// Ports       : clk, rst          - clock, synchronous active-low reset
//               i_start           - 1-cycle request, latches i_word/i_two_bytes
//               i_two_bytes       - 1: send two bytes, 0: send the low byte only
//               i_word            - response word
//               i_tx_busy         - transmitter busy
//               o_tx_p_data       - byte to transmit (registered)
//               o_tx_d_valid      - 1-cycle launch pulse (registered)
//               o_done            - 1-cycle pulse once the last byte has left
// Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl_tx_seq
    import uart_sys_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ALU_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_two_bytes,
    input  logic [ALU_W-1:0]  i_word,
    input  logic              i_tx_busy,
    output logic [DATA_W-1:0] o_tx_p_data,
    output logic              o_tx_d_valid,
    output logic              o_done
);

    sys_ctrl_state_e   r_state;
    sys_ctrl_state_e   w_state_nxt;
    logic [ALU_W-1:0]  r_word;
    logic              r_more;

    logic              w_tx_d_valid;
    logic [DATA_W-1:0] w_tx_p_data;
    logic              w_done;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (i_start)    w_state_nxt = ST_TX_SEND;
            ST_TX_SEND: if (!i_tx_busy) w_state_nxt = ST_TX_GAP;
            ST_TX_GAP:                  w_state_nxt = ST_TX_WAIT;
            ST_TX_WAIT: if (!i_tx_busy) w_state_nxt = r_more ? ST_TX_SEND : ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_tx_d_valid = 1'b0;
        w_tx_p_data  = o_tx_p_data;
        w_done       = 1'b0;
        case (r_state)
            ST_TX_SEND: begin
                if (!i_tx_busy) begin
                    w_tx_d_valid = 1'b1;
                    w_tx_p_data  = r_word[DATA_W-1:0];
                end
            end
            ST_TX_WAIT: begin
                if (!i_tx_busy && !r_more) begin
                    w_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Byte buffer: the word is shifted down after the first byte so that the
    // next byte to send is always in the low lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word <= '0;
            r_more <= 1'b0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_word <= i_word;
            r_more <= i_two_bytes;
        end else if (r_state == ST_TX_WAIT && !i_tx_busy && r_more) begin
            r_word <= r_word >> DATA_W;
            r_more <= 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_tx_d_valid <= 1'b0;
            o_tx_p_data  <= '0;
            o_done       <= 1'b0;
        end else begin
            o_tx_d_valid <= w_tx_d_valid;
            o_tx_p_data  <= w_tx_p_data;
            o_done       <= w_done;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_sys_ctrl
// Description : Command sequencer between the UART and the register file /
//               ALU. Parses command bytes from the UART receiver, issues RF
//               write/read strobes and ALU starts, waits (bounded) for the
//               RF/ALU responses and returns results over the UART TX.
// Ports       : clk, rst                 - clock, synchronous active-low reset
//               rx_p_data, rx_d_valid    - received byte and its valid pulse
//               rf_wr_en, rf_rd_en       - RF write / read strobes
//               rf_addr, rf_wr_data      - RF address and write data
//               rf_rd_data, rf_rd_valid  - RF read response
//               alu_en, alu_fun          - ALU start strobe and function
//               alu_out, alu_out_valid   - ALU result
//               tx_p_data, tx_d_valid    - byte to transmit and launch pulse
//               tx_busy                  - UART transmitter busy
//               cmd_err                  - unknown opcode / response timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sys_ctrl
    import uart_sys_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int FUN_W    = 4,
    parameter int ALU_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_p_data,
    input  logic              rx_d_valid,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic              rf_rd_valid,
    output logic              alu_en,
    output logic [FUN_W-1:0]  alu_fun,
    input  logic [ALU_W-1:0]  alu_out,
    input  logic              alu_out_valid,
    output logic [DATA_W-1:0] tx_p_data,
    output logic              tx_d_valid,
    input  logic              tx_busy,
    output logic              cmd_err
);

    localparam int                 c_CNT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_MAX);

    sys_ctrl_state_e    r_state;
    sys_ctrl_state_e    w_state_nxt;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0]  r_addr;

    logic               w_is_wait;
    logic               w_timeout;
    logic               w_known_op;

    logic               w_rf_wr_en;
    logic               w_rf_rd_en;
    logic               w_alu_en;
    logic               w_cmd_err;
    logic [ADDR_W-1:0]  w_rf_addr;
    logic [DATA_W-1:0]  w_rf_wr_data;
    logic [FUN_W-1:0]   w_alu_fun;

    logic               w_tx_start;
    logic               w_tx_two;
    logic [ALU_W-1:0]   w_tx_word;
    logic               w_tx_done;

    assign w_is_wait  = (r_state == ST_RD_WAIT) || (r_state == ST_ALU_WAIT);
    assign w_timeout  = w_is_wait && (r_wait_cnt == c_WAIT_LAST);
    assign w_known_op = (rx_p_data == DATA_W'(OP_RF_WR))  ||
                        (rx_p_data == DATA_W'(OP_RF_RD))  ||
                        (rx_p_data == DATA_W'(OP_ALU_OP)) ||
                        (rx_p_data == DATA_W'(OP_ALU_NOP));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Bytes arriving in wait/TX states fall through the
    // case without effect, and so do responses outside their wait state.
    // ST_TX_SEND stands for the whole transmit phase here; the byte-level
    // SEND/GAP/WAIT sequencing lives in the TX scheduler.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_d_valid) begin
                    if (rx_p_data == DATA_W'(OP_RF_WR))        w_state_nxt = ST_WR_ADDR;
                    else if (rx_p_data == DATA_W'(OP_RF_RD))   w_state_nxt = ST_RD_ADDR;
                    else if (rx_p_data == DATA_W'(OP_ALU_OP))  w_state_nxt = ST_OP_A;
                    else if (rx_p_data == DATA_W'(OP_ALU_NOP)) w_state_nxt = ST_ALU_FUN;
                end
            end
            ST_WR_ADDR:  if (rx_d_valid)    w_state_nxt = ST_WR_DATA;
            ST_WR_DATA:  if (rx_d_valid)    w_state_nxt = ST_IDLE;
            ST_RD_ADDR:  if (rx_d_valid)    w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (rf_rd_valid)            w_state_nxt = ST_TX_SEND;
                else if (w_timeout)         w_state_nxt = ST_IDLE;
            end
            ST_OP_A:     if (rx_d_valid)    w_state_nxt = ST_OP_B;
            ST_OP_B:     if (rx_d_valid)    w_state_nxt = ST_ALU_FUN;
            ST_ALU_FUN:  if (rx_d_valid)    w_state_nxt = ST_ALU_WAIT;
            ST_ALU_WAIT: begin
                if (alu_out_valid)          w_state_nxt = ST_TX_SEND;
                else if (w_timeout)         w_state_nxt = ST_IDLE;
            end
            ST_TX_SEND:  if (w_tx_done)     w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, so every strobe
    // appears the cycle after the byte/response that caused it.
    always_comb begin
        w_rf_wr_en   = 1'b0;
        w_rf_rd_en   = 1'b0;
        w_alu_en     = 1'b0;
        w_cmd_err    = 1'b0;
        w_rf_addr    = rf_addr;
        w_rf_wr_data = rf_wr_data;
        w_alu_fun    = alu_fun;
        w_tx_start   = 1'b0;
        w_tx_two     = 1'b0;
        w_tx_word    = '0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_err = rx_d_valid && !w_known_op;
            end
            ST_WR_DATA: begin
                if (rx_d_valid) begin
                    w_rf_wr_en   = 1'b1;
                    w_rf_addr    = r_addr;
                    w_rf_wr_data = rx_p_data;
                end
            end
            ST_RD_ADDR: begin
                if (rx_d_valid) begin
                    w_rf_rd_en = 1'b1;
                    w_rf_addr  = rx_p_data[ADDR_W-1:0];
                end
            end
            ST_RD_WAIT: begin
                if (rf_rd_valid) begin
                    w_tx_start = 1'b1;
                    w_tx_word  = ALU_W'(rf_rd_data);
                end else if (w_timeout) begin
                    w_cmd_err = 1'b1;
                end
            end
            ST_OP_A: begin
                if (rx_d_valid) begin
                    w_rf_wr_en   = 1'b1;
                    w_rf_addr    = ADDR_W'(OPND_A_ADDR);
                    w_rf_wr_data = rx_p_data;
                end
            end
            ST_OP_B: begin
                if (rx_d_valid) begin
                    w_rf_wr_en   = 1'b1;
                    w_rf_addr    = ADDR_W'(OPND_B_ADDR);
                    w_rf_wr_data = rx_p_data;
                end
            end
            ST_ALU_FUN: begin
                if (rx_d_valid) begin
                    w_alu_en  = 1'b1;
                    w_alu_fun = rx_p_data[FUN_W-1:0];
                end
            end
            ST_ALU_WAIT: begin
                if (alu_out_valid) begin
                    w_tx_start = 1'b1;
                    w_tx_two   = 1'b1;
                    w_tx_word  = alu_out;
                end else if (w_timeout) begin
                    w_cmd_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Wait counter restarts on every state change, so it is zero on entry
    // to either wait state; it never wraps because the timeout exits first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_is_wait) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_state == ST_WR_ADDR && rx_d_valid) begin
                r_addr <= rx_p_data[ADDR_W-1:0];
            end
        end
    end

    // Registered RF/ALU/error outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            cmd_err    <= 1'b0;
        end else begin
            rf_wr_en   <= w_rf_wr_en;
            rf_rd_en   <= w_rf_rd_en;
            rf_addr    <= w_rf_addr;
            rf_wr_data <= w_rf_wr_data;
            alu_en     <= w_alu_en;
            alu_fun    <= w_alu_fun;
            cmd_err    <= w_cmd_err;
        end
    end

    sys_ctrl_tx_seq #(
        .DATA_W (DATA_W),
        .ALU_W  (ALU_W)
    ) u_tx_seq (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_tx_start),
        .i_two_bytes  (w_tx_two),
        .i_word       (w_tx_word),
        .i_tx_busy    (tx_busy),
        .o_tx_p_data  (tx_p_data),
        .o_tx_d_valid (tx_d_valid),
        .o_done       (w_tx_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_sys_ctrl
// Description : Scoreboard bench for uart_sys_ctrl. Commands push their
//               expected RF/ALU/TX/error events into a queue; a monitor pops
//               and compares whenever the DUT strobes. RF, ALU and UART TX
//               are modelled as simple responders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sys_ctrl;

    localparam int WAIT_MAX = 255;
    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_ALU = 2;
    localparam int EV_TX  = 3;
    localparam int EV_ERR = 4;

    logic        clk           = 1'b0;
    logic        rst           = 1'b0;
    logic [7:0]  rx_p_data     = '0;
    logic        rx_d_valid    = 1'b0;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data    = '0;
    logic        rf_rd_valid   = 1'b0;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out       = '0;
    logic        alu_out_valid = 1'b0;
    logic [7:0]  tx_p_data;
    logic        tx_d_valid;
    logic        tx_busy       = 1'b0;
    logic        cmd_err;

    always #5 clk = ~clk;

    uart_sys_ctrl #(
        .DATA_W(8), .ADDR_W(4), .FUN_W(4), .ALU_W(16), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid), .tx_busy(tx_busy),
        .cmd_err(cmd_err)
    );

    typedef struct {
        int kind;
        int a;
        int b;
        bit timeout;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         t_alu    = 0;
    logic [7:0] ref_mem[16];     // reference view of the register file
    logic [7:0] env_mem[16];     // register file model driven by the DUT
    int         rd_delay   = 0;
    int         alu_delay  = 0;
    bit         alu_noresp = 1'b0;
    int         spur_req   = 0;
    int         spur_ack   = 0;
    string      kname[5]   = '{"wr", "rd", "alu", "tx", "err"};

    function automatic void check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endfunction

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input int f);
        case (f)
            0:       return 16'(a) + 16'(b);
            1:       return 16'(a) - 16'(b);
            2:       return 16'(a) * 16'(b);
            3:       return {a, b};
            default: return {8'h00, a ^ b} + 16'(f);
        endcase
    endfunction

    function automatic void push(input int kind, input int a, input int b, input bit to);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.timeout = to;
        exp_q.push_back(e);
    endfunction

    function automatic void expect_ev(input int kind, input int a, input int b);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", kname[kind]}, kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check({kname[e.kind], "_kind"}, kind, e.kind);
        check({kname[e.kind], "_field"}, a, e.a);
        if (e.kind == EV_WR) check("wr_data", b, e.b);
        if (e.kind == EV_ERR && e.timeout) check("timeout_latency", cyc - t_alu, WAIT_MAX + 1);
    endfunction

    // Monitor
    initial begin : monitor
        int ns;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                ns = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_d_valid) + int'(cmd_err);
                if (ns > 0) begin
                    check("strobe_exclusive", ns, 1);
                    if (alu_en) t_alu = cyc;
                    if (rf_wr_en)   expect_ev(EV_WR, int'(rf_addr), int'(rf_wr_data));
                    if (rf_rd_en)   expect_ev(EV_RD, int'(rf_addr), 0);
                    if (alu_en)     expect_ev(EV_ALU, int'(alu_fun), 0);
                    if (tx_d_valid) expect_ev(EV_TX, int'(tx_p_data), 0);
                    if (cmd_err)    expect_ev(EV_ERR, 0, 0);
                end
            end
        end
    end

    // RF and ALU responders
    initial begin : rf_alu_env
        int         rd_cnt;
        int         al_cnt;
        int         al_f;
        logic [3:0] rd_a;
        rd_cnt = -1; al_cnt = -1; al_f = 0; rd_a = '0;
        for (int i = 0; i < 16; i++) env_mem[i] = '0;
        forever begin
            @(negedge clk);
            rf_rd_valid   = 1'b0;
            alu_out_valid = 1'b0;
            if (rd_cnt == 0) begin
                rf_rd_valid = 1'b1;
                rf_rd_data  = env_mem[rd_a];
            end
            if (al_cnt == 0) begin
                alu_out_valid = 1'b1;
                alu_out       = alu_model(env_mem[0], env_mem[1], al_f);
            end
            if (rd_cnt >= 0) rd_cnt--;
            if (al_cnt >= 0) al_cnt--;
            if (spur_req != spur_ack) begin
                spur_ack      = spur_req;
                rf_rd_valid   = 1'b1;
                alu_out_valid = 1'b1;
                rf_rd_data    = 8'h99;
                alu_out       = 16'h9999;
            end
            if (rst) begin
                if (rf_wr_en) env_mem[rf_addr] = rf_wr_data;
                if (rf_rd_en) begin
                    rd_a   = rf_addr;
                    rd_cnt = rd_delay;
                end
                if (alu_en && !alu_noresp) begin
                    al_cnt = alu_delay;
                    al_f   = int'(alu_fun);
                end
            end
        end
    end

    // UART TX model: busy for a few cycles after each launched byte
    initial begin : tx_env
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst && tx_d_valid) begin
                check("tx_while_busy", int'(tx_busy), 0);
                bcnt = $urandom_range(2, 6);
            end else if (bcnt > 0) begin
                bcnt--;
            end
            tx_busy = (bcnt > 0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_p_data  = b;
        rx_d_valid = 1'b1;
        @(negedge clk);
        rx_d_valid = 1'b0;
        rx_p_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("idle_bound", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        n = 0;
        while (tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic cmd_wr(input logic [7:0] a, input logic [7:0] d);
        push(EV_WR, int'(a[3:0]), int'(d), 1'b0);
        ref_mem[a[3:0]] = d;
        send_byte(8'hAA, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        send_byte(d, 0);
        wait_idle();
    endtask

    task automatic cmd_rd(input logic [7:0] a, input int dly, input bit junk);
        rd_delay = dly;
        push(EV_RD, int'(a[3:0]), 0, 1'b0);
        push(EV_TX, int'(ref_mem[a[3:0]]), 0, 1'b0);
        send_byte(8'hBB, $urandom_range(0, 2));
        if (junk) begin
            send_byte(a, 0);
            send_byte(8'hAA, 0);       // arrives in RD_WAIT, must be dropped
        end else begin
            send_byte(a, 0);
        end
        wait_idle();
    endtask

    task automatic cmd_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        logic [15:0] r;
        alu_delay = $urandom_range(0, 6);
        ref_mem[0] = a;
        ref_mem[1] = b;
        r = alu_model(a, b, int'(f[3:0]));
        push(EV_WR, 0, int'(a), 1'b0);
        push(EV_WR, 1, int'(b), 1'b0);
        push(EV_ALU, int'(f[3:0]), 0, 1'b0);
        push(EV_TX, int'(r[7:0]), 0, 1'b0);
        push(EV_TX, int'(r[15:8]), 0, 1'b0);
        send_byte(8'hCC, $urandom_range(0, 2));
        send_byte(a, $urandom_range(0, 2));
        send_byte(b, $urandom_range(0, 2));
        send_byte(f, 0);
        wait_idle();
    endtask

    task automatic cmd_alu_nop(input logic [7:0] f, input bit noresp);
        logic [15:0] r;
        alu_delay  = $urandom_range(0, 6);
        alu_noresp = noresp;
        r = alu_model(ref_mem[0], ref_mem[1], int'(f[3:0]));
        push(EV_ALU, int'(f[3:0]), 0, 1'b0);
        if (noresp) begin
            push(EV_ERR, 0, 0, 1'b1);
        end else begin
            push(EV_TX, int'(r[7:0]), 0, 1'b0);
            push(EV_TX, int'(r[15:8]), 0, 1'b0);
        end
        send_byte(8'hDD, $urandom_range(0, 2));
        send_byte(f, 0);
        wait_idle();
        alu_noresp = 1'b0;
    endtask

    task automatic cmd_bad(input logic [7:0] op);
        push(EV_ERR, 0, 0, 1'b0);
        send_byte(op, 0);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_wr_en"},   int'(rf_wr_en), 0);
        check({tag, "_rf_rd_en"},   int'(rf_rd_en), 0);
        check({tag, "_rf_addr"},    int'(rf_addr), 0);
        check({tag, "_rf_wr_data"}, int'(rf_wr_data), 0);
        check({tag, "_alu_en"},     int'(alu_en), 0);
        check({tag, "_alu_fun"},    int'(alu_fun), 0);
        check({tag, "_tx_valid"},   int'(tx_d_valid), 0);
        check({tag, "_tx_data"},    int'(tx_p_data), 0);
        check({tag, "_cmd_err"},    int'(cmd_err), 0);
    endtask

    initial begin : stimulus
        logic [7:0] op;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        cmd_wr(8'h05, 8'h3C);
        cmd_rd(8'h05, 2, 1'b0);
        cmd_alu_op(8'h07, 8'h03, 8'h00);
        cmd_bad(8'h5E);
        cmd_wr(8'h01, 8'hFF);
        cmd_alu_nop(8'h02, 1'b1);
        cmd_rd(8'h01, 4, 1'b1);

        // Reset in the middle of a write command
        send_byte(8'hAA, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst1");
        rst = 1'b1;
        @(negedge clk);
        cmd_bad(8'h05);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1: cmd_wr(8'($urandom), 8'($urandom));
                2: begin
                    int d;
                    d = $urandom_range(0, 7);
                    cmd_rd(8'($urandom), d, (d >= 3) && ($urandom_range(0, 1) == 1));
                end
                3: cmd_alu_op(8'($urandom), 8'($urandom), 8'($urandom));
                4: cmd_alu_nop(8'($urandom), $urandom_range(0, 7) == 0);
                default: begin
                    op = 8'($urandom);
                    while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD) op = 8'($urandom);
                    cmd_bad(op);
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                spur_req++;             // stray responses while idle must be ignored
                repeat (3) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
